// File: rtl/lsu_access_ctrl.sv
// lsu_access_ctrl: access controller between the pipeline and a byte-addressed
// data memory with combinational read and posedge write.
// Handles RV32 load/store sizes, legality and alignment checks, and load
// sign/zero extension.
// Optional feature: define LSU_MISALIGN_SPLIT_EN to split misaligned
// halfword/word accesses into byte accesses. Without it, misaligned
// accesses are rejected with resp_err.
module lsu_access_ctrl #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [2:0]        req_fun3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic              resp_err,
  output logic [31:0]       resp_rdata,
  output logic              busy,
  output logic              mem_read,
  output logic              mem_write,
  output logic [2:0]        mem_fun3,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    SPLIT  = 2'd2,
    RESP   = 2'd3
  } state_t;

  // Sign- or zero-extend raw load data according to the load funct3.
  function automatic logic [31:0] load_extend(input logic [2:0] f, input logic [31:0] d);
    logic [31:0] v;
    case (f)
      3'b000:  v = {{24{d[7]}}, d[7:0]};
      3'b001:  v = {{16{d[15]}}, d[15:0]};
      3'b100:  v = {24'd0, d[7:0]};
      3'b101:  v = {16'd0, d[15:0]};
      default: v = d;
    endcase
    return v;
  endfunction

  state_t            r_state, w_state_nxt;
  logic              r_ready, w_ready_nxt;
  logic              r_busy, w_busy_nxt;
  logic              r_resp_valid, w_resp_valid_nxt;
  logic              r_resp_err, w_resp_err_nxt;
  logic [31:0]       r_resp_rdata, w_resp_rdata_nxt;
  logic              r_mem_read, w_mem_read_nxt;
  logic              r_mem_write, w_mem_write_nxt;
  logic [2:0]        r_mem_fun3, w_mem_fun3_nxt;
  logic [ADDR_W-1:0] r_mem_addr, w_mem_addr_nxt;
  logic [31:0]       r_mem_wdata, w_mem_wdata_nxt;
  logic              r_write, w_write_nxt;
  logic [2:0]        r_fun3, w_fun3_nxt;
  logic [1:0]        w_size;
  logic              w_legal;
  logic              w_misal;
`ifdef LSU_MISALIGN_SPLIT_EN
  logic [ADDR_W-1:0] r_addr, w_addr_nxt;
  logic [31:0]       r_wdata, w_wdata_nxt;
  logic [31:0]       r_asm, w_asm_nxt, w_asm_upd;
  logic [1:0]        r_cnt, w_cnt_nxt, w_cnt_inc;
  logic [1:0]        r_last, w_last_nxt;
  logic [7:0]        w_wbyte;
`endif

  // Classify the incoming request: fun3 legality for its direction and alignment.
  always_comb begin
    w_size = req_fun3[1:0];
    if (req_write) begin
      w_legal = (req_fun3 == 3'b000) || (req_fun3 == 3'b001) || (req_fun3 == 3'b010);
    end else begin
      w_legal = (req_fun3 == 3'b000) || (req_fun3 == 3'b001) || (req_fun3 == 3'b010) ||
                (req_fun3 == 3'b100) || (req_fun3 == 3'b101);
    end
    case (w_size)
      2'b01:   w_misal = req_addr[0];
      2'b10:   w_misal = (req_addr[1:0] != 2'b00);
      default: w_misal = 1'b0;
    endcase
  end

`ifdef LSU_MISALIGN_SPLIT_EN
  // Split byte lanes: merge the returned byte into the assembly word and pick the next store byte.
  always_comb begin
    w_cnt_inc = r_cnt + 2'd1;
    w_asm_upd = r_asm;
    case (r_cnt)
      2'd0:    w_asm_upd[7:0]   = mem_rdata[7:0];
      2'd1:    w_asm_upd[15:8]  = mem_rdata[7:0];
      2'd2:    w_asm_upd[23:16] = mem_rdata[7:0];
      default: w_asm_upd[31:24] = mem_rdata[7:0];
    endcase
    case (w_cnt_inc)
      2'd1:    w_wbyte = r_wdata[15:8];
      2'd2:    w_wbyte = r_wdata[23:16];
      2'd3:    w_wbyte = r_wdata[31:24];
      default: w_wbyte = r_wdata[7:0];
    endcase
  end
`endif

  // Next-state and next-output logic; memory strobes and the response are registered.
  always_comb begin
    w_state_nxt      = r_state;
    w_resp_valid_nxt = 1'b0;
    w_resp_err_nxt   = 1'b0;
    w_resp_rdata_nxt = 32'd0;
    w_mem_read_nxt   = 1'b0;
    w_mem_write_nxt  = 1'b0;
    w_mem_fun3_nxt   = 3'b000;
    w_mem_addr_nxt   = {ADDR_W{1'b0}};
    w_mem_wdata_nxt  = 32'd0;
    w_write_nxt      = r_write;
    w_fun3_nxt       = r_fun3;
`ifdef LSU_MISALIGN_SPLIT_EN
    w_addr_nxt       = r_addr;
    w_wdata_nxt      = r_wdata;
    w_asm_nxt        = r_asm;
    w_cnt_nxt        = r_cnt;
    w_last_nxt       = r_last;
`endif
    case (r_state)
      IDLE: begin
        if (req_valid) begin
          w_write_nxt = req_write;
          w_fun3_nxt  = req_fun3;
          if (!w_legal) begin
            w_state_nxt      = RESP;
            w_resp_valid_nxt = 1'b1;
            w_resp_err_nxt   = 1'b1;
          end else if (!w_misal) begin
            w_state_nxt     = ACCESS;
            w_mem_read_nxt  = !req_write;
            w_mem_write_nxt = req_write;
            w_mem_fun3_nxt  = req_fun3;
            w_mem_addr_nxt  = req_addr;
            w_mem_wdata_nxt = req_write ? req_wdata : 32'd0;
          end else begin
`ifdef LSU_MISALIGN_SPLIT_EN
            w_state_nxt     = SPLIT;
            w_addr_nxt      = req_addr;
            w_wdata_nxt     = req_wdata;
            w_asm_nxt       = 32'd0;
            w_cnt_nxt       = 2'd0;
            w_last_nxt      = (w_size == 2'b01) ? 2'd1 : 2'd3;
            w_mem_read_nxt  = !req_write;
            w_mem_write_nxt = req_write;
            w_mem_fun3_nxt  = req_write ? 3'b000 : 3'b100;
            w_mem_addr_nxt  = req_addr;
            w_mem_wdata_nxt = req_write ? {24'd0, req_wdata[7:0]} : 32'd0;
`else
            w_state_nxt      = RESP;
            w_resp_valid_nxt = 1'b1;
            w_resp_err_nxt   = 1'b1;
`endif
          end
        end else begin
          w_state_nxt = IDLE;
        end
      end
      ACCESS: begin
        w_state_nxt      = RESP;
        w_resp_valid_nxt = 1'b1;
        w_resp_rdata_nxt = r_write ? 32'd0 : load_extend(r_fun3, mem_rdata);
      end
`ifdef LSU_MISALIGN_SPLIT_EN
      SPLIT: begin
        w_asm_nxt = w_asm_upd;
        if (r_cnt == r_last) begin
          w_state_nxt      = RESP;
          w_resp_valid_nxt = 1'b1;
          w_resp_rdata_nxt = r_write ? 32'd0 : load_extend(r_fun3, w_asm_upd);
        end else begin
          w_state_nxt     = SPLIT;
          w_cnt_nxt       = w_cnt_inc;
          w_mem_read_nxt  = !r_write;
          w_mem_write_nxt = r_write;
          w_mem_fun3_nxt  = r_write ? 3'b000 : 3'b100;
          w_mem_addr_nxt  = r_addr + ADDR_W'(w_cnt_inc);
          w_mem_wdata_nxt = r_write ? {24'd0, w_wbyte} : 32'd0;
        end
      end
`endif
      RESP: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
    w_ready_nxt = (w_state_nxt == IDLE);
    w_busy_nxt  = (w_state_nxt != IDLE);
  end

  // State, capture and output registers; reset returns to IDLE with everything cleared.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_ready      <= 1'b1;
      r_busy       <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= 32'd0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_mem_fun3   <= 3'b000;
      r_mem_addr   <= {ADDR_W{1'b0}};
      r_mem_wdata  <= 32'd0;
      r_write      <= 1'b0;
      r_fun3       <= 3'b000;
`ifdef LSU_MISALIGN_SPLIT_EN
      r_addr       <= {ADDR_W{1'b0}};
      r_wdata      <= 32'd0;
      r_asm        <= 32'd0;
      r_cnt        <= 2'd0;
      r_last       <= 2'd0;
`endif
    end else begin
      r_state      <= w_state_nxt;
      r_ready      <= w_ready_nxt;
      r_busy       <= w_busy_nxt;
      r_resp_valid <= w_resp_valid_nxt;
      r_resp_err   <= w_resp_err_nxt;
      r_resp_rdata <= w_resp_rdata_nxt;
      r_mem_read   <= w_mem_read_nxt;
      r_mem_write  <= w_mem_write_nxt;
      r_mem_fun3   <= w_mem_fun3_nxt;
      r_mem_addr   <= w_mem_addr_nxt;
      r_mem_wdata  <= w_mem_wdata_nxt;
      r_write      <= w_write_nxt;
      r_fun3       <= w_fun3_nxt;
`ifdef LSU_MISALIGN_SPLIT_EN
      r_addr       <= w_addr_nxt;
      r_wdata      <= w_wdata_nxt;
      r_asm        <= w_asm_nxt;
      r_cnt        <= w_cnt_nxt;
      r_last       <= w_last_nxt;
`endif
    end
  end

  assign req_ready  = r_ready;
  assign busy       = r_busy;
  assign resp_valid = r_resp_valid;
  assign resp_err   = r_resp_err;
  assign resp_rdata = r_resp_rdata;
  assign mem_read   = r_mem_read;
  assign mem_write  = r_mem_write;
  assign mem_fun3   = r_mem_fun3;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;

endmodule

// File: tb/tb_lsu_access_ctrl.sv
// tb_lsu_access_ctrl: self-checking bench for lsu_access_ctrl with a 256-byte
// memory model and a byte-level reference model of load/store behaviour.
module tb_lsu_access_ctrl;
  localparam int ADDR_W = 8;
`ifdef LSU_MISALIGN_SPLIT_EN
  localparam bit SPLIT_EN = 1'b1;
`else
  localparam bit SPLIT_EN = 1'b0;
`endif

  logic        clk, rst;
  logic        req_valid, req_ready, req_write;
  logic [2:0]  req_fun3;
  logic [7:0]  req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid, resp_err, busy;
  logic [31:0] resp_rdata;
  logic        mem_read, mem_write;
  logic [2:0]  mem_fun3;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] mem     [256];
  logic [7:0] img     [256];
  logic [7:0] ref_mem [256];
  logic       preset_req;

  logic [7:0] obs_addr [8];
  logic [2:0] obs_fun3 [8];
  logic [7:0] obs_wb   [8];
  logic       obs_rd   [8];

  lsu_access_ctrl #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_fun3(req_fun3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
    .busy(busy), .mem_read(mem_read), .mem_write(mem_write),
    .mem_fun3(mem_fun3), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data memory: little-endian combinational read of four bytes, wrapping.
  logic [7:0] ra1, ra2, ra3;
  always_comb begin
    ra1 = mem_addr + 8'd1;
    ra2 = mem_addr + 8'd2;
    ra3 = mem_addr + 8'd3;
  end
  assign mem_rdata = {mem[ra3], mem[ra2], mem[ra1], mem[mem_addr]};

  // Data memory write port (sized by mem_fun3) plus a bench preset path.
  always @(posedge clk) begin
    if (preset_req) begin
      for (int i = 0; i < 256; i++) mem[i] <= img[i];
    end else if (mem_write) begin
      mem[mem_addr] <= mem_wdata[7:0];
      if (mem_fun3[1:0] != 2'b00) mem[ra1] <= mem_wdata[15:8];
      if (mem_fun3[1:0] == 2'b10) begin
        mem[ra2] <= mem_wdata[23:16];
        mem[ra3] <= mem_wdata[31:24];
      end
    end
  end

  task automatic preset();
    for (int i = 0; i < 256; i++) img[i] = ref_mem[i];
    preset_req = 1'b1;
    @(posedge clk);
    #1 preset_req = 1'b0;
  endtask

  // Reference model: outcome of one request from the architectural rules; stores update ref_mem.
  task automatic model(input logic w, input logic [2:0] f, input logic [7:0] a, input logic [31:0] d,
                       output int lat, output logic e, output logic [31:0] rd, output int nstb);
    int nb;
    bit legal, misal;
    logic [31:0] v;
    nb    = (f[1:0] == 2'd0) ? 1 : (f[1:0] == 2'd1) ? 2 : 4;
    legal = w ? (f <= 3'd2) : (f <= 3'd2 || f == 3'd4 || f == 3'd5);
    misal = (int'(a) % nb) != 0;
    rd = 32'd0; e = 1'b0; nstb = 0; lat = 1;
    if (!legal || (misal && !SPLIT_EN)) begin
      e = 1'b1;
    end else begin
      nstb = misal ? nb : 1;
      lat  = nstb + 1;
      v = 32'd0;
      for (int i = 0; i < nb; i++) v = v | (32'(ref_mem[8'(int'(a) + i)]) << (8 * i));
      if (w) begin
        for (int i = 0; i < nb; i++) ref_mem[8'(int'(a) + i)] = d[8 * i +: 8];
      end else begin
        if (!f[2] && nb == 1 && v[7])  v = v | 32'hFFFFFF00;
        if (!f[2] && nb == 2 && v[15]) v = v | 32'hFFFF0000;
        rd = v;
      end
    end
  endtask

  // Drive one request (caller is at a negedge with the DUT idle) and observe until the response.
  task automatic do_access(input logic w, input logic [2:0] f, input logic [7:0] a, input logic [31:0] d,
                           input bit hold, output int lat, output logic [31:0] rd, output logic er,
                           output int nstb, output bit proto_bad, output bit not_ready);
    not_ready = (req_ready !== 1'b1);
    req_valid = 1'b1; req_write = w; req_fun3 = f; req_addr = a; req_wdata = d;
    lat = 0; rd = 32'd0; er = 1'b0; nstb = 0; proto_bad = 1'b0;
    @(posedge clk);
    for (int k = 1; k <= 12 && lat == 0; k++) begin
      @(negedge clk);
      if (hold) begin
        req_write = 1'($urandom_range(0, 1));
        req_fun3  = 3'($urandom_range(0, 7));
        req_addr  = 8'($urandom_range(0, 255));
        req_wdata = $urandom;
      end else begin
        req_valid = 1'b0;
      end
      if (mem_read || mem_write) begin
        if (nstb < 8) begin
          obs_addr[nstb] = mem_addr; obs_fun3[nstb] = mem_fun3;
          obs_wb[nstb] = mem_wdata[7:0]; obs_rd[nstb] = mem_read;
        end
        nstb++;
      end else if (mem_fun3 != 3'b000 || mem_addr != 8'h00 || mem_wdata != 32'd0) begin
        proto_bad = 1'b1;
      end
      if (mem_read && mem_write) proto_bad = 1'b1;
      if (busy !== 1'b1 || req_ready !== 1'b0) proto_bad = 1'b1;
      if (resp_valid === 1'b1) begin
        lat = k; rd = resp_rdata; er = resp_err;
      end
    end
    req_valid = 1'b0; req_write = 1'b0; req_fun3 = 3'b000; req_addr = 8'h00; req_wdata = 32'd0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++; if (req_ready !== 1'b1) begin n_errors++; $display("FAIL reset_ready: got %b expected 1", req_ready); end
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if ({resp_valid, resp_err, resp_rdata} !== 34'd0) begin n_errors++; $display("FAIL reset_resp: got %b/%b/%h expected all 0", resp_valid, resp_err, resp_rdata); end
    n_checks++; if ({mem_read, mem_write, mem_fun3, mem_addr, mem_wdata} !== 45'd0) begin n_errors++; $display("FAIL reset_mem: got rd=%b wr=%b f=%h a=%h d=%h expected all 0", mem_read, mem_write, mem_fun3, mem_addr, mem_wdata); end
    rst = 1'b0;
  endtask

  task automatic test_directed();
    int lat, nstb, dl, dn, nbad;
    logic [31:0] rd, drd, mw;
    logic er, de;
    bit pb, nr;
    logic [7:0] ea [4];
    logic [7:0] ewb [4];
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
    ref_mem[0] = 8'h0A; ref_mem[1] = 8'h0D; ref_mem[2] = 8'h1E; ref_mem[3] = 8'h00; ref_mem[255] = 8'h80;
    preset();

    @(negedge clk);
    do_access(1'b0, 3'b010, 8'h00, 32'd0, 1'b0, lat, rd, er, nstb, pb, nr);
    n_checks++; if (lat !== 2 || er !== 1'b0) begin n_errors++; $display("FAIL lw00_timing: got lat=%0d err=%b expected lat=2 err=0", lat, er); end
    n_checks++; if (rd !== 32'h001E0D0A) begin n_errors++; $display("FAIL lw00_rdata: got %h expected 001e0d0a", rd); end
    n_checks++; if (nstb !== 1 || obs_rd[0] !== 1'b1 || obs_addr[0] !== 8'h00 || obs_fun3[0] !== 3'b010) begin n_errors++; $display("FAIL lw00_strobe: got n=%0d rd=%b a=%h f=%h expected n=1 rd=1 a=00 f=2", nstb, obs_rd[0], obs_addr[0], obs_fun3[0]); end

    @(negedge clk);
    do_access(1'b0, 3'b001, 8'h01, 32'd0, 1'b0, lat, rd, er, nstb, pb, nr);
`ifdef LSU_MISALIGN_SPLIT_EN
    n_checks++; if (lat !== 3 || er !== 1'b0 || rd !== 32'h00001E0D) begin n_errors++; $display("FAIL lh01_split: got lat=%0d err=%b rdata=%h expected lat=3 err=0 rdata=00001e0d", lat, er, rd); end
    n_checks++; if (nstb !== 2 || obs_addr[0] !== 8'h01 || obs_addr[1] !== 8'h02 || obs_fun3[0] !== 3'b100 || obs_fun3[1] !== 3'b100 || obs_rd[0] !== 1'b1 || obs_rd[1] !== 1'b1) begin n_errors++; $display("FAIL lh01_strobes: got n=%0d a=%h,%h f=%h,%h expected n=2 a=01,02 f=4,4", nstb, obs_addr[0], obs_addr[1], obs_fun3[0], obs_fun3[1]); end
`else
    n_checks++; if (lat !== 1 || er !== 1'b1 || rd !== 32'd0 || nstb !== 0) begin n_errors++; $display("FAIL lh01_reject: got lat=%0d err=%b rdata=%h n=%0d expected lat=1 err=1 rdata=0 n=0", lat, er, rd, nstb); end
    @(negedge clk);
    do_access(1'b0, 3'b010, 8'h02, 32'd0, 1'b0, lat, rd, er, nstb, pb, nr);
    n_checks++; if (lat !== 1 || er !== 1'b1 || rd !== 32'd0 || nstb !== 0) begin n_errors++; $display("FAIL lw02_reject: got lat=%0d err=%b rdata=%h n=%0d expected lat=1 err=1 rdata=0 n=0", lat, er, rd, nstb); end
`endif

    @(negedge clk);
    do_access(1'b0, 3'b000, 8'hFF, 32'd0, 1'b0, lat, rd, er, nstb, pb, nr);
    n_checks++; if (lat !== 2 || rd !== 32'hFFFFFF80) begin n_errors++; $display("FAIL lbff: got lat=%0d rdata=%h expected lat=2 rdata=ffffff80", lat, rd); end
    @(negedge clk);
    do_access(1'b0, 3'b100, 8'hFF, 32'd0, 1'b0, lat, rd, er, nstb, pb, nr);
    n_checks++; if (lat !== 2 || rd !== 32'h00000080) begin n_errors++; $display("FAIL lbuff: got lat=%0d rdata=%h expected lat=2 rdata=00000080", lat, rd); end

    @(negedge clk);
    do_access(1'b0, 3'b011, 8'h00, 32'd0, 1'b0, lat, rd, er, nstb, pb, nr);
    n_checks++; if (lat !== 1 || er !== 1'b1 || rd !== 32'd0 || nstb !== 0) begin n_errors++; $display("FAIL ld011_illegal: got lat=%0d err=%b rdata=%h n=%0d expected lat=1 err=1 rdata=0 n=0", lat, er, rd, nstb); end

    @(negedge clk);
    model(1'b1, 3'b010, 8'hFE, 32'h11223344, dl, de, drd, dn);
    do_access(1'b1, 3'b010, 8'hFE, 32'h11223344, 1'b0, lat, rd, er, nstb, pb, nr);
    mw = {mem[8'hFE], mem[8'hFF], mem[8'h00], mem[8'h01]};
`ifdef LSU_MISALIGN_SPLIT_EN
    ea  = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    ewb = '{8'h44, 8'h33, 8'h22, 8'h11};
    nbad = 0;
    for (int k = 0; k < 4; k++)
      if (obs_addr[k] !== ea[k] || obs_wb[k] !== ewb[k] || obs_fun3[k] !== 3'b000 || obs_rd[k] !== 1'b0) nbad++;
    n_checks++; if (lat !== 5 || er !== 1'b0 || rd !== 32'd0) begin n_errors++; $display("FAIL swfe_timing: got lat=%0d err=%b rdata=%h expected lat=5 err=0 rdata=0", lat, er, rd); end
    n_checks++; if (nstb !== 4 || nbad !== 0) begin n_errors++; $display("FAIL swfe_strobes: got n=%0d bad=%0d expected n=4 bad=0", nstb, nbad); end
    n_checks++; if (mw !== 32'h44332211) begin n_errors++; $display("FAIL swfe_mem: got FE..01=%h expected 44332211", mw); end
`else
    n_checks++; if (lat !== 1 || er !== 1'b1 || nstb !== 0) begin n_errors++; $display("FAIL swfe_reject: got lat=%0d err=%b n=%0d expected lat=1 err=1 n=0", lat, er, nstb); end
    n_checks++; if (mw !== 32'h00800A0D) begin n_errors++; $display("FAIL swfe_mem: got FE..01=%h expected 00800a0d", mw); end
`endif
  endtask

  task automatic test_reset_abort();
    int seen;
    logic [31:0] mw;
    ref_mem[8'hFE] = 8'h00; ref_mem[8'hFF] = 8'h80; ref_mem[8'h00] = 8'h0A; ref_mem[8'h01] = 8'h0D;
    preset();
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_fun3 = 3'b010; req_wdata = 32'h11223344;
`ifdef LSU_MISALIGN_SPLIT_EN
    req_addr = 8'hFE;
`else
    req_addr = 8'h00;
`endif
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
`ifdef LSU_MISALIGN_SPLIT_EN
    repeat (2) @(negedge clk);
`endif
    rst = 1'b1;
    #1;
    n_checks++; if (busy !== 1'b0 || req_ready !== 1'b1 || mem_write !== 1'b0 || resp_valid !== 1'b0) begin n_errors++; $display("FAIL reset_async: got busy=%b ready=%b wr=%b rv=%b expected 0,1,0,0", busy, req_ready, mem_write, resp_valid); end
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (resp_valid !== 1'b0 || mem_write !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1) seen++;
    end
    n_checks++; if (seen !== 0) begin n_errors++; $display("FAIL reset_abort_quiet: got %0d active cycles expected 0", seen); end
    mw = {mem[8'hFE], mem[8'hFF], mem[8'h00], mem[8'h01]};
`ifdef LSU_MISALIGN_SPLIT_EN
    n_checks++; if (mw !== 32'h44330A0D) begin n_errors++; $display("FAIL reset_abort_mem: got FE..01=%h expected 44330a0d", mw); end
    ref_mem[8'hFE] = 8'h44; ref_mem[8'hFF] = 8'h33;
`else
    n_checks++; if (mw !== 32'h00800A0D) begin n_errors++; $display("FAIL reset_abort_mem: got FE..01=%h expected 00800a0d", mw); end
`endif
  endtask

  task automatic test_busy_ignore();
    int lat, nstb, nd;
    logic [31:0] rd;
    logic er;
    bit pb, nr;
    for (int r = 0; r < 3; r++) begin
      @(negedge clk);
      do_access(1'b0, 3'b010, 8'h00, 32'd0, 1'b1, lat, rd, er, nstb, pb, nr);
      nd = 0;
      for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) nd++;
      n_checks++; if (lat !== 2 || er !== 1'b0 || rd !== 32'h001E0D0A || nstb !== 1 || pb || nr) begin n_errors++; $display("FAIL busy_ignore_%0d: got lat=%0d err=%b rdata=%h n=%0d proto=%b expected lat=2 err=0 rdata=001e0d0a n=1 proto=0", r, lat, er, rd, nstb, pb); end
      n_checks++; if (nd !== 0) begin n_errors++; $display("FAIL busy_ignore_mem_%0d: got %0d changed bytes expected 0", r, nd); end
    end
  endtask

  task automatic test_random_back_to_back(input int n);
    int lat, e_lat, nstb, e_nstb, nd, nbad;
    logic [31:0] rd, e_rd, d;
    logic er, e_er, w;
    logic [2:0] f, ef;
    logic [7:0] a;
    bit pb, nr;
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'($urandom_range(0, 255));
    preset();
    @(negedge clk);
    for (int t = 0; t < n; t++) begin
      w = 1'($urandom_range(0, 1));
      f = 3'($urandom_range(0, 7));
      a = 8'($urandom_range(0, 255));
      d = $urandom;
      model(w, f, a, d, e_lat, e_er, e_rd, e_nstb);
      do_access(w, f, a, d, (t % 5 == 4), lat, rd, er, nstb, pb, nr);
      nbad = 0;
      for (int k = 0; k < e_nstb && k < 8; k++) begin
        ef = (e_nstb > 1) ? (w ? 3'b000 : 3'b100) : f;
        if (obs_addr[k] !== 8'(int'(a) + k) || obs_fun3[k] !== ef || obs_rd[k] !== !w) nbad++;
        if (w && obs_wb[k] !== d[8 * k +: 8]) nbad++;
      end
      nd = 0;
      for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) nd++;
      n_checks++; if (nr) begin n_errors++; $display("FAIL rnd_ready t=%0d: got req_ready=0 at accept expected 1", t); end
      n_checks++; if (lat !== e_lat) begin n_errors++; $display("FAIL rnd_latency t=%0d w=%b f=%h a=%h: got %0d expected %0d", t, w, f, a, lat, e_lat); end
      n_checks++; if (er !== e_er) begin n_errors++; $display("FAIL rnd_err t=%0d w=%b f=%h a=%h: got %b expected %b", t, w, f, a, er, e_er); end
      n_checks++; if (rd !== e_rd) begin n_errors++; $display("FAIL rnd_rdata t=%0d w=%b f=%h a=%h: got %h expected %h", t, w, f, a, rd, e_rd); end
      n_checks++; if (nstb !== e_nstb || nbad !== 0) begin n_errors++; $display("FAIL rnd_strobes t=%0d w=%b f=%h a=%h: got n=%0d bad=%0d expected n=%0d bad=0", t, w, f, a, nstb, nbad, e_nstb); end
      n_checks++; if (pb) begin n_errors++; $display("FAIL rnd_protocol t=%0d: got violation expected none", t); end
      n_checks++; if (nd !== 0) begin n_errors++; $display("FAIL rnd_mem t=%0d w=%b f=%h a=%h: got %0d differing bytes expected 0", t, w, f, a, nd); end
      @(negedge clk);
      n_checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0) begin n_errors++; $display("FAIL rnd_idle t=%0d: got rv=%b ready=%b busy=%b expected 0,1,0", t, resp_valid, req_ready, busy); end
    end
  endtask

  initial begin
    rst = 1'b1; preset_req = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_fun3 = 3'b000; req_addr = 8'h00; req_wdata = 32'd0;
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
    test_reset();
    test_directed();
    test_reset_abort();
    test_busy_ignore();
    test_random_back_to_back(150);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/lsu_access_ctrl.md
LSU_ACCESS_CTRL -- requirements
Module: lsu_access_ctrl

Interface
REQ-001 Parameter: ADDR_W, default 8, byte-address width of the data memory port.
REQ-002 Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  pipeline access request.
- req_ready  out  1  block can accept a request.
- req_write  in  1  1 = store, 0 = load.
- req_fun3  in  3  RV32 funct3 of the load/store.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data.
- resp_valid  out  1  one-cycle completion pulse.
- resp_err  out  1  qualified by resp_valid; access rejected.
- resp_rdata  out  32  load result, qualified by resp_valid.
- busy  out  1  request in flight; pipeline stall.
- mem_read / mem_write  out  1  data-memory strobes.
- mem_fun3  out  3  data-memory access size/sign.
- mem_addr  out  ADDR_W  data-memory byte address.
- mem_wdata  out  32  data-memory write data.
- mem_rdata  in  32  data-memory combinational read data.

Function
REQ-003 The block SHALL sit between the pipeline and the byte-addressed data memory (combinational read, write on posedge when mem_write=1).
REQ-004 The FSM SHALL have states IDLE, ACCESS, SPLIT and RESP.
- req_ready = (state==IDLE).
- busy = (state!=IDLE).
REQ-005 In IDLE, a request SHALL be accepted when req_valid=1 (cycle T); all req_* fields are latched at T.
REQ-006 Legal fun3 values:
- loads: 000, 001, 010, 100, 101.
- stores: 000, 001, 010.
- Any other value: no memory strobe, RESP at T+1 with resp_err=1 and resp_rdata=0.
REQ-007 Alignment rules:
- Byte accesses are always aligned.
- Halfword is aligned iff addr[0]=0.
- Word is aligned iff addr[1:0]=0.
REQ-008 Aligned access: ACCESS at T+1, which SHALL drive mem_fun3=req_fun3 and mem_addr=addr with one strobe for exactly that cycle. Loads capture mem_rdata at the end of that cycle.
REQ-009 Misaligned access (macro defined): SPLIT for N cycles, T+1..T+N, where N=2 for halfword and N=4 for word. Byte k SHALL be issued at cycle T+1+k with:
- mem_addr = (addr+k) mod 2^ADDR_W, so addresses wrap.
- Stores: mem_fun3=000 and mem_wdata[7:0] = wdata[8k+7:8k].
- Loads: mem_fun3=100 and mem_rdata[7:0] captured into assembly byte k.
REQ-010 Response timing: RESP SHALL follow the last access cycle (T+2 aligned, T+N+1 split), then return to IDLE.
REQ-011 Response content:
- resp_valid=1 for exactly one cycle.
- resp_err=0.
- Loads: resp_rdata is sign-extended (000/001) or zero-extended (100/101) per the latched fun3.
- Stores: resp_rdata=0.
REQ-012 Outside ACCESS/SPLIT, mem_read, mem_write, mem_fun3, mem_addr and mem_wdata SHALL be 0. mem_read and mem_write SHALL never be high together.
REQ-013 req_valid during busy SHALL be ignored; there is no queueing.
REQ-014 A new request SHALL NOT be accepted in the RESP cycle. Minimum spacing between accepts is 3 cycles aligned and N+2 cycles split.

Reset
REQ-015 On rst=1, the state SHALL go to IDLE immediately, asynchronously.
REQ-016 While in reset, all outputs and capture registers SHALL be 0 except req_ready=1.
REQ-017 Reset during SPLIT SHALL abort the request with no response. Bytes already written stay written; remaining bytes are never issued.

Configuration
REQ-018 Macro LSU_MISALIGN_SPLIT_EN controls misaligned handling:
- Defined: misaligned accesses SHALL be split per REQ-009.
- Undefined: misaligned accesses SHALL issue no memory strobe and SHALL complete at T+1 with resp_err=1 and resp_rdata=0; SPLIT logic is absent.

Verification
REQ-019 The bench SHALL cover these directed scenarios (memory preset mem[0..3]=0A,0D,1E,00, mem[FF]=80):
- LW addr 0x00 -> one mem_read at T+1; resp at T+2 with rdata 0x001E0D0A, err 0.
- LH addr 0x01 (split) -> mem_read with fun3 100 at 0x01, 0x02; resp at T+3 with rdata 0x00001E0D.
- LB addr 0xFF -> rdata 0xFFFFFF80; LBU addr 0xFF -> rdata 0x00000080.
- SW addr 0xFE, data 0x11223344 (split) -> mem[FE]=44, [FF]=33, [00]=22, [01]=11 on T+1..T+4; resp at T+5.
- Same SW with rst pulsed after 2 byte writes -> only mem[FE] and mem[FF] changed, no resp_valid, req_ready=1.
- Macro undefined: LW addr 0x02 -> no strobe; resp at T+1 with err 1. Load fun3=011 -> err 1 in both builds.
